// File: rtl/dvi_tx_timing_ctrl.sv
// DVI/HDMI transmit timing generator: IDLE/RUN/DRAIN FSM, hsync/vsync/de with one cycle of output latency, no backpressure.
// Define DVI_TX_TEST_PATTERN_EN to replace the pass-through RGB with an internal 8-bar colour pattern.
module dvi_tx_timing_ctrl #(
  parameter int   H_ACTIVE = 1280,
  parameter int   H_FP     = 110,
  parameter int   H_SYNC   = 40,
  parameter int   H_BP     = 220,
  parameter int   V_ACTIVE = 720,
  parameter int   V_FP     = 5,
  parameter int   V_SYNC   = 5,
  parameter int   V_BP     = 20,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1
) (
  input  logic       I_rgb_clk,
  input  logic       I_rst_n,
  input  logic       I_en,
  input  logic [7:0] I_rgb_r,
  input  logic [7:0] I_rgb_g,
  input  logic [7:0] I_rgb_b,
  output logic       O_data_req,
  output logic       O_rgb_vs,
  output logic       O_rgb_hs,
  output logic       O_rgb_de,
  output logic [7:0] O_rgb_r,
  output logic [7:0] O_rgb_g,
  output logic [7:0] O_rgb_b,
  output logic       O_frame_start,
  output logic       O_busy
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int H_W     = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int V_W     = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

  // One extra bit so region bounds equal to TOTAL still compare correctly.
  localparam logic [H_W:0] H_SYNC_END = (H_W + 1)'(H_SYNC);
  localparam logic [H_W:0] H_ACT_BEG  = (H_W + 1)'(H_SYNC + H_BP);
  localparam logic [H_W:0] H_ACT_END  = (H_W + 1)'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [H_W:0] H_LAST     = (H_W + 1)'(H_TOTAL - 1);
  localparam logic [V_W:0] V_SYNC_END = (V_W + 1)'(V_SYNC);
  localparam logic [V_W:0] V_ACT_BEG  = (V_W + 1)'(V_SYNC + V_BP);
  localparam logic [V_W:0] V_ACT_END  = (V_W + 1)'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [V_W:0] V_LAST     = (V_W + 1)'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [H_W-1:0] r_h_cnt;
  logic [V_W-1:0] r_v_cnt;

  logic       w_h_last;
  logic       w_v_last;
  logic       w_frame_last;
  logic       w_h_sync;
  logic       w_v_sync;
  logic       w_h_act;
  logic       w_v_act;
  logic       w_live;
  logic       w_data_req;
  logic [7:0] w_pix_r;
  logic [7:0] w_pix_g;
  logic [7:0] w_pix_b;

  logic       r_hs;
  logic       r_vs;
  logic       r_de;
  logic       r_fs;
  logic [7:0] r_r;
  logic [7:0] r_g;
  logic [7:0] r_b;

  assign w_h_last     = ({1'b0, r_h_cnt} == H_LAST);
  assign w_v_last     = ({1'b0, r_v_cnt} == V_LAST);
  assign w_frame_last = w_h_last && w_v_last;
  assign w_h_sync     = ({1'b0, r_h_cnt} <  H_SYNC_END);
  assign w_v_sync     = ({1'b0, r_v_cnt} <  V_SYNC_END);
  assign w_h_act      = ({1'b0, r_h_cnt} >= H_ACT_BEG) && ({1'b0, r_h_cnt} < H_ACT_END);
  assign w_v_act      = ({1'b0, r_v_cnt} >= V_ACT_BEG) && ({1'b0, r_v_cnt} < V_ACT_END);
  assign w_live       = (r_state != S_IDLE);
  assign w_data_req   = w_live && w_h_act && w_v_act;

  // Dropping I_en only requests a stop; the frame in flight always completes.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (I_en) w_state_nxt = S_RUN;
      S_RUN:   if (!I_en) w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (I_en) begin
          w_state_nxt = S_RUN;
        end else if (w_frame_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

`ifdef DVI_TX_TEST_PATTERN_EN
  logic [2:0] w_bar;
  logic       w_unused_rgb;

  assign w_bar        = 3'(((int'(r_h_cnt) - (H_SYNC + H_BP)) * 8) / H_ACTIVE);
  assign w_pix_r      = {8{w_bar[2]}};
  assign w_pix_g      = {8{w_bar[1]}};
  assign w_pix_b      = {8{w_bar[0]}};
  assign w_unused_rgb = ^{I_rgb_r, I_rgb_g, I_rgb_b};
`else
  assign w_pix_r = I_rgb_r;
  assign w_pix_g = I_rgb_g;
  assign w_pix_b = I_rgb_b;
`endif

  always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_hs <= ~HS_POL;
      r_vs <= ~VS_POL;
      r_de <= 1'b0;
      r_fs <= 1'b0;
      r_r  <= '0;
      r_g  <= '0;
      r_b  <= '0;
    end else begin
      r_hs <= (w_live && w_h_sync) ? HS_POL : ~HS_POL;
      r_vs <= (w_live && w_v_sync) ? VS_POL : ~VS_POL;
      r_de <= w_data_req;
      // A frame wrapping while draining is a continuation, not a new frame.
      r_fs <= (r_state == S_RUN) && (r_h_cnt == '0) && (r_v_cnt == '0);
      r_r  <= w_data_req ? w_pix_r : '0;
      r_g  <= w_data_req ? w_pix_g : '0;
      r_b  <= w_data_req ? w_pix_b : '0;
    end
  end

  assign O_data_req    = w_data_req;
  assign O_rgb_hs      = r_hs;
  assign O_rgb_vs      = r_vs;
  assign O_rgb_de      = r_de;
  assign O_rgb_r       = r_r;
  assign O_rgb_g       = r_g;
  assign O_rgb_b       = r_b;
  assign O_frame_start = r_fs;
  assign O_busy        = w_live;

endmodule

// File: tb/tb_dvi_tx_timing_ctrl.sv
// Bench for dvi_tx_timing_ctrl on a 14x7 raster (98-cycle frame); reference model tracks frame position arithmetically.
module tb_dvi_tx_timing_ctrl;

  localparam int HT = 14;
  localparam int VT = 7;
  localparam int FT = HT * VT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] ir = '0, ig = '0, ib = '0;
  logic       o_req, o_vs, o_hs, o_de, o_fs, o_busy;
  logic [7:0] o_r, o_g, o_b;

  dvi_tx_timing_ctrl #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .I_rgb_clk(clk), .I_rst_n(rst_n), .I_en(en),
    .I_rgb_r(ir), .I_rgb_g(ig), .I_rgb_b(ib),
    .O_data_req(o_req), .O_rgb_vs(o_vs), .O_rgb_hs(o_hs), .O_rgb_de(o_de),
    .O_rgb_r(o_r), .O_rgb_g(o_g), .O_rgb_b(o_b),
    .O_frame_start(o_fs), .O_busy(o_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: is a frame in flight, has a stop been requested, position within frame.
  bit m_busy = 0, m_stop = 0;
  int m_pos = 0;
  logic       e_hs = 0, e_vs = 0, e_de = 0, e_fs = 0;
  logic [7:0] e_r = 0, e_g = 0, e_b = 0;

  int n_hs, n_vs, n_de, n_fs, n_busy, sum_r;

  function automatic bit f_act(input int p);
    return ((p % HT) >= 4) && ((p % HT) < 12) && ((p / HT) >= 2) && ((p / HT) < 6);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_counts();
    n_hs = 0; n_vs = 0; n_de = 0; n_fs = 0; n_busy = 0; sum_r = 0;
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input logic t_en, input logic [7:0] t_r, input logic [7:0] t_g, input logic [7:0] t_b);
    bit act;
    int bar;
    en = t_en; ir = t_r; ig = t_g; ib = t_b;
    #1;
    act = m_busy && f_act(m_pos);
    check_eq("data_req", o_req, act);
    check_eq("busy", o_busy, m_busy);
    check_eq("hs", o_hs, e_hs);
    check_eq("vs", o_vs, e_vs);
    check_eq("de", o_de, e_de);
    check_eq("frame_start", o_fs, e_fs);
    check_eq("rgb", {o_r, o_g, o_b}, {e_r, e_g, e_b});
    n_hs += o_hs; n_vs += o_vs; n_de += o_de; n_fs += o_fs; n_busy += o_busy;
    if (o_de) sum_r += o_r;
    @(posedge clk);
    e_hs = m_busy && ((m_pos % HT) < 2);
    e_vs = m_busy && ((m_pos / HT) < 1);
    e_de = act;
    e_fs = m_busy && !m_stop && (m_pos == 0);
`ifdef DVI_TX_TEST_PATTERN_EN
    bar = (m_pos % HT) - 4;
    e_r = (act && bar[2]) ? 8'hFF : 8'h00;
    e_g = (act && bar[1]) ? 8'hFF : 8'h00;
    e_b = (act && bar[0]) ? 8'hFF : 8'h00;
`else
    bar = 0;
    e_r = act ? t_r : 8'h00;
    e_g = act ? t_g : 8'h00;
    e_b = act ? t_b : 8'h00;
`endif
    if (!m_busy) begin
      if (t_en) begin m_busy = 1; m_stop = 0; end
      m_pos = 0;
    end else begin
      if (t_en) m_stop = 0;
      else if (m_stop && m_pos == FT - 1) m_busy = 0;
      else m_stop = 1;
      m_pos = (m_pos + 1) % FT;
    end
    @(negedge clk);
  endtask

  task automatic rstep(input logic t_en);
    step(t_en, 8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic run_to(input logic t_en, input int target);
    int guard = 0;
    while (m_pos != target && guard < 300) begin rstep(t_en); guard++; end
    check_eq("reach_pos", m_pos, target);
  endtask

  task automatic do_reset(input logic rel_en);
    rst_n = 1'b0;
    #1;
    check_eq("rst_de", o_de, 1'b0);
    check_eq("rst_hs", o_hs, 1'b0);
    check_eq("rst_vs", o_vs, 1'b0);
    check_eq("rst_busy", o_busy, 1'b0);
    check_eq("rst_req", o_req, 1'b0);
    check_eq("rst_fs", o_fs, 1'b0);
    check_eq("rst_rgb", {o_r, o_g, o_b}, 24'h0);
    m_busy = 0; m_stop = 0; m_pos = 0;
    e_hs = 0; e_vs = 0; e_de = 0; e_fs = 0; e_r = 0; e_g = 0; e_b = 0;
    @(posedge clk);
    @(negedge clk);
    en = rel_en;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int nsteps;
    @(negedge clk);
    do_reset(1'b0);
    repeat (3) rstep(1'b0);

    // Continuous frame: raster shape, de count, pixel order tagged by h position.
    step(1'b1, 8'h0, 8'h0, 8'h0);
    step(1'b1, 8'h0, 8'h0, 8'h0);
    clear_counts();
    for (int k = 0; k < FT; k++) step(1'b1, 8'(m_pos % HT), 8'($urandom), 8'($urandom));
    check_eq("frame_hs_cycles", n_hs, 14);
    check_eq("frame_vs_cycles", n_vs, 14);
    check_eq("frame_de_cycles", n_de, 32);
    check_eq("frame_fs_count", n_fs, 1);
`ifdef DVI_TX_TEST_PATTERN_EN
    check_eq("frame_sum_r", sum_r, 4 * 4 * 255);
`else
    check_eq("frame_sum_r", sum_r, 4 * (4 + 5 + 6 + 7 + 8 + 9 + 10 + 11));
`endif

    // Stop requested at cycle 40: frame completes, then idle with no new frame.
    run_to(1'b1, 40);
    clear_counts();
    repeat (150) rstep(1'b0);
    check_eq("drain_busy_cycles", n_busy, FT - 40);
    check_eq("drain_fs_count", n_fs, 0);
    check_eq("drain_end_busy", o_busy, 1'b0);

    // Stop at 40, resume at 60: no gap and the next frame is announced.
    rstep(1'b1);
    run_to(1'b1, 40);
    run_to(1'b0, 60);
    clear_counts();
    nsteps = 0;
    while (m_pos != 2 && nsteps < 200) begin rstep(1'b1); nsteps++; end
    check_eq("resume_busy_cycles", n_busy, nsteps);
    check_eq("resume_fs_count", n_fs, 1);

    // Reset in the middle of the active area, then a fresh frame.
    run_to(1'b1, 3 * HT + 6);
    check_eq("pre_reset_de", o_de, 1'b1);
    do_reset(1'b1);
    rstep(1'b1);
    rstep(1'b1);
    clear_counts();
    rstep(1'b1);
    check_eq("post_reset_fs", n_fs, 1);

    // Randomised enable toggling, data and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) == 0) do_reset(1'($urandom));
      else if ($urandom_range(0, 39) == 0) rstep(~en);
      else rstep(en);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
